// File: rtl/cdi_rle_pkg.sv
// Shared constants and types for the CD-i CLUT7 RLE encoder.
// Line lengths, run limits and the encoder state enum.
package cdi_rle_pkg;

  localparam logic [8:0] LINE_LEN_NORMAL = 9'd384;
  localparam logic [8:0] LINE_LEN_ST     = 9'd360;
  localparam logic [8:0] MAX_RUN         = 9'd255;
  localparam logic [8:0] MIN_RUN         = 9'd3;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    FLUSH_CODE,
    FLUSH_COUNT,
    FLUSH_SINGLE
  } enc_state_e;

  function automatic logic [8:0] clip_run(logic [8:0] len);
    return (len > MAX_RUN) ? MAX_RUN : len;
  endfunction

endpackage

// File: rtl/clut_rle_encoder.sv
// CLUT7 run-length encoder: 7-bit pixel line in, RLE7 byte stream out.
// Moore outputs; passthrough bypasses the encoder entirely.
module clut_rle_encoder
  import cdi_rle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       st,
  input  logic       passthrough,
  input  logic [7:0] src_pixel,
  input  logic       src_write,
  output logic       src_strobe,
  output logic [7:0] dst_pixel,
  output logic       dst_write,
  input  logic       dst_strobe,
  output logic       line_end
);

  enc_state_e state;
  logic [6:0] run_pix;
  logic [6:0] pend_pix;
  logic [8:0] run_len;
  logic [8:0] line_cnt;
  logic       pend_valid;
  logic       pend_eol;
  logic       eol;
  logic       rdy;
  logic       out_valid;
  logic       out_last;
  logic [7:0] out_byte;

  logic [6:0] in_pix;
  logic [8:0] line_eff;
  logic [8:0] run_inc;
  logic [8:0] emit_cnt;
  logic [8:0] run_rem;
  logic       accept;
  logic       xfer;
  logic       last_pix;
  logic       same_pix;

  assign in_pix   = src_pixel[6:0];
  assign accept   = rdy && src_write;
  assign xfer     = out_valid && dst_strobe;
  // line_cnt==0 marks a line start, where st is sampled
  assign line_eff = (line_cnt == 9'd0) ?
                    (st ? LINE_LEN_ST : LINE_LEN_NORMAL) :
                    line_cnt;
  assign last_pix = (line_eff == 9'd1);
  assign same_pix = (in_pix == run_pix);
  assign run_inc  = run_len + 9'd1;
  assign emit_cnt = clip_run(run_len);
  assign run_rem  = (state == FLUSH_SINGLE) ? run_len - 9'd1 :
                    eol ? 9'd0 : run_len - emit_cnt;

  assign src_strobe = passthrough ? dst_strobe : rdy;
  assign dst_write  = passthrough ? src_write : out_valid;
  assign dst_pixel  = passthrough ? src_pixel : out_byte;
  assign line_end   = !passthrough && out_valid &&
                      out_last && dst_strobe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      run_pix    <= '0;
      pend_pix   <= '0;
      run_len    <= '0;
      line_cnt   <= '0;
      pend_valid <= 1'b0;
      pend_eol   <= 1'b0;
      eol        <= 1'b0;
      rdy        <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_byte   <= '0;
    end else if (passthrough) begin
      state      <= IDLE;
      run_len    <= '0;
      line_cnt   <= '0;
      pend_valid <= 1'b0;
      pend_eol   <= 1'b0;
      eol        <= 1'b0;
      rdy        <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          rdy <= 1'b1;
          if (accept) begin
            run_pix  <= in_pix;
            run_len  <= 9'd1;
            line_cnt <= line_eff - 9'd1;
            if (last_pix) begin
              eol       <= 1'b1;
              rdy       <= 1'b0;
              state     <= FLUSH_SINGLE;
              out_valid <= 1'b1;
              out_byte  <= {1'b0, in_pix};
              out_last  <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            line_cnt <= line_eff - 9'd1;
            if (same_pix) begin
              run_len <= run_inc;
              if (last_pix) begin
                eol       <= 1'b1;
                rdy       <= 1'b0;
                out_valid <= 1'b1;
                out_last  <= 1'b0;
                if (run_inc >= MIN_RUN) begin
                  state    <= FLUSH_CODE;
                  out_byte <= {1'b1, run_pix};
                end else begin
                  state    <= FLUSH_SINGLE;
                  out_byte <= {1'b0, run_pix};
                end
              end
            end else begin
              pend_pix   <= in_pix;
              pend_valid <= 1'b1;
              pend_eol   <= last_pix;
              rdy        <= 1'b0;
              out_valid  <= 1'b1;
              out_last   <= 1'b0;
              if (run_len >= MIN_RUN) begin
                state    <= FLUSH_CODE;
                out_byte <= {1'b1, run_pix};
              end else begin
                state    <= FLUSH_SINGLE;
                out_byte <= {1'b0, run_pix};
              end
            end
          end
        end
        FLUSH_CODE: begin
          if (xfer) begin
            state    <= FLUSH_COUNT;
            out_byte <= eol ? 8'h00 : emit_cnt[7:0];
            out_last <= eol;
          end
        end
        FLUSH_COUNT, FLUSH_SINGLE: begin
          if (xfer) begin
            run_len  <= run_rem;
            out_last <= 1'b0;
            if (run_rem >= MIN_RUN) begin
              state    <= FLUSH_CODE;
              out_byte <= {1'b1, run_pix};
            end else if (run_rem != 9'd0) begin
              state    <= FLUSH_SINGLE;
              out_byte <= {1'b0, run_pix};
              out_last <= eol && (run_rem == 9'd1);
            end else if (pend_valid) begin
              run_pix    <= pend_pix;
              run_len    <= 9'd1;
              pend_valid <= 1'b0;
              pend_eol   <= 1'b0;
              if (pend_eol) begin
                eol      <= 1'b1;
                state    <= FLUSH_SINGLE;
                out_byte <= {1'b0, pend_pix};
                out_last <= 1'b1;
              end else begin
                state     <= ACCUM;
                out_valid <= 1'b0;
                rdy       <= 1'b1;
              end
            end else begin
              state     <= IDLE;
              eol       <= 1'b0;
              out_valid <= 1'b0;
              rdy       <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clut_rle_encoder.sv
// Directed bench for clut_rle_encoder: table of whole lines with
// hand-computed RLE7 bytes, plus stall, reset and passthrough cases.
module tb_clut_rle_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       st;
  logic       passthrough;
  logic [7:0] src_pixel;
  logic       src_write;
  logic       src_strobe;
  logic [7:0] dst_pixel;
  logic       dst_write;
  logic       dst_strobe;
  logic       line_end;

  int nvec = 0;
  int nbad = 0;

  clut_rle_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .st         (st),
    .passthrough(passthrough),
    .src_pixel  (src_pixel),
    .src_write  (src_write),
    .src_strobe (src_strobe),
    .dst_pixel  (dst_pixel),
    .dst_write  (dst_write),
    .dst_strobe (dst_strobe),
    .line_end   (line_end)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            st;
    logic            noise;
    logic [2:0][7:0] pix;
    logic [2:0][8:0] cnt;
    logic [3:0]      n;
    logic [5:0][7:0] exp;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(
    logic st_i, logic noise,
    logic [7:0] p0, int c0,
    logic [7:0] p1, int c1,
    logic [7:0] p2, int c2,
    int n,
    logic [7:0] e0, logic [7:0] e1,
    logic [7:0] e2, logic [7:0] e3,
    logic [7:0] e4, logic [7:0] e5);
    vec_t v;
    v.st     = st_i;
    v.noise  = noise;
    v.pix[0] = p0;
    v.pix[1] = p1;
    v.pix[2] = p2;
    v.cnt[0] = 9'(c0);
    v.cnt[1] = 9'(c1);
    v.cnt[2] = 9'(c2);
    v.n      = 4'(n);
    v.exp[0] = e0;
    v.exp[1] = e1;
    v.exp[2] = e2;
    v.exp[3] = e3;
    v.exp[4] = e4;
    v.exp[5] = e5;
    return v;
  endfunction

  function automatic logic [7:0] pix_at(vec_t v, int i);
    int b0;
    int b1;
    logic [7:0] p;
    b0 = int'(v.cnt[0]);
    b1 = b0 + int'(v.cnt[1]);
    if (i < b0) p = v.pix[0];
    else if (i < b1) p = v.pix[1];
    else p = v.pix[2];
    if (v.noise && i[0]) p[7] = ~p[7];
    return p;
  endfunction

  task automatic check8(string nm, logic [7:0] act,
                        logic [7:0] want);
    nvec++;
    if (act !== want) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic check_int(string nm, int act, int want);
    nvec++;
    if (act != want) begin
      nbad++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  // Feed one line and collect bytes until line_end (bounded).
  task automatic run_line(input int id, input vec_t v,
                          input int stall);
    int total;
    int ip;
    int nout;
    int le_at;
    int stall_left;
    logic done;
    logic [7:0] got[16];
    for (int k = 0; k < 16; k++) got[k] = 8'hxx;
    total = int'(v.cnt[0]) + int'(v.cnt[1]) + int'(v.cnt[2]);
    ip = 0;
    nout = 0;
    le_at = -1;
    done = 1'b0;
    stall_left = stall;
    st = v.st;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      src_write = (ip < total);
      src_pixel = pix_at(v, ip);
      if (dst_write && stall_left > 0) begin
        dst_strobe = 1'b0;
        #1;
        check8($sformatf("v%0d_stall_hold", id),
               dst_pixel, v.exp[0]);
        check_int($sformatf("v%0d_stall_nosrc", id),
                  int'(src_strobe), 0);
        stall_left--;
      end else begin
        dst_strobe = 1'b1;
        #1;
      end
      if (src_write && src_strobe) ip++;
      if (dst_write && dst_strobe) begin
        if (nout < 16) got[nout] = dst_pixel;
        if (line_end) begin
          le_at = nout;
          done = 1'b1;
        end
        nout++;
      end
      @(posedge clk);
      #1;
    end
    src_write = 1'b0;
    dst_strobe = 1'b0;
    check_int($sformatf("v%0d_done", id), int'(done), 1);
    check_int($sformatf("v%0d_nbytes", id), nout, int'(v.n));
    check_int($sformatf("v%0d_npix", id), ip, total);
    check_int($sformatf("v%0d_line_end_at", id),
              le_at, int'(v.n) - 1);
    for (int k = 0; k < int'(v.n); k++)
      check8($sformatf("v%0d_byte%0d", id, k), got[k], v.exp[k]);
  endtask

  initial begin
    int cnt;
    int nout;

    vecs[0] = mk(0, 0, 8'h00, 384, 8'h00, 0, 8'h00, 0, 2,
                 8'h80, 8'h00, 0, 0, 0, 0);
    vecs[1] = mk(1, 0, 8'h05, 3, 8'h07, 357, 8'h00, 0, 4,
                 8'h85, 8'h03, 8'h87, 8'h00, 0, 0);
    vecs[2] = mk(0, 0, 8'h01, 1, 8'h02, 2, 8'h03, 381, 5,
                 8'h01, 8'h02, 8'h02, 8'h83, 8'h00, 0);
    vecs[3] = mk(0, 0, 8'h09, 300, 8'h04, 84, 8'h00, 0, 6,
                 8'h89, 8'hFF, 8'h89, 8'h2D, 8'h84, 8'h00);
    vecs[4] = mk(1, 0, 8'h7F, 358, 8'h10, 2, 8'h00, 0, 6,
                 8'hFF, 8'hFF, 8'hFF, 8'h67, 8'h10, 8'h10);
    vecs[5] = mk(0, 0, 8'h03, 383, 8'h55, 1, 8'h00, 0, 5,
                 8'h83, 8'hFF, 8'h83, 8'h80, 8'h55, 0);
    vecs[6] = mk(0, 1, 8'h85, 384, 8'h00, 0, 8'h00, 0, 2,
                 8'h85, 8'h00, 0, 0, 0, 0);
    vecs[7] = mk(0, 0, 8'h06, 256, 8'h02, 128, 8'h00, 0, 5,
                 8'h86, 8'hFF, 8'h06, 8'h82, 8'h00, 0);
    vecs[8] = mk(0, 0, 8'h06, 255, 8'h02, 129, 8'h00, 0, 4,
                 8'h86, 8'hFF, 8'h82, 8'h00, 0, 0);
    vecs[9] = mk(1, 0, 8'h2A, 1, 8'h2B, 359, 8'h00, 0, 3,
                 8'h2A, 8'hAB, 8'h00, 0, 0, 0);

    reset = 1'b1;
    st = 1'b0;
    passthrough = 1'b0;
    src_pixel = 8'h00;
    src_write = 1'b0;
    dst_strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_int("rst_dst_write", int'(dst_write), 0);
    check_int("rst_src_strobe", int'(src_strobe), 0);
    check_int("rst_line_end", int'(line_end), 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_line(i, vecs[i], 0);

    // CODE byte held under a 5-cycle stall
    run_line(10, mk(0, 0, 8'h22, 384, 8'h00, 0, 8'h00, 0, 2,
                    8'hA2, 8'h00, 0, 0, 0, 0), 5);

    // reset in the middle of a run
    st = 1'b0;
    dst_strobe = 1'b1;
    src_pixel = 8'h33;
    src_write = 1'b1;
    cnt = 0;
    nout = 0;
    for (int c = 0; c < 300 && cnt < 100; c++) begin
      if (src_strobe) cnt++;
      if (dst_write) nout++;
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    check_int("midrst_dst_write", int'(dst_write), 0);
    check_int("midrst_src_strobe", int'(src_strobe), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    src_write = 1'b0;
    check_int("midrst_pix", cnt, 100);
    check_int("midrst_nobytes", nout, 0);
    run_line(11, mk(0, 0, 8'h11, 384, 8'h00, 0, 8'h00, 0, 2,
                    8'h91, 8'h00, 0, 0, 0, 0), 0);

    // passthrough handshake
    passthrough = 1'b1;
    src_pixel = 8'hAB;
    src_write = 1'b1;
    dst_strobe = 1'b0;
    #1;
    check8("pt_pixel", dst_pixel, 8'hAB);
    check_int("pt_write", int'(dst_write), 1);
    check_int("pt_strobe_lo", int'(src_strobe), 0);
    check_int("pt_no_line_end", int'(line_end), 0);
    dst_strobe = 1'b1;
    #1;
    check_int("pt_strobe_hi", int'(src_strobe), 1);
    src_write = 1'b0;
    #1;
    check_int("pt_write_lo", int'(dst_write), 0);
    @(posedge clk);
    #1;
    passthrough = 1'b0;

    // passthrough raised mid-run discards the partial line
    src_pixel = 8'h44;
    src_write = 1'b1;
    cnt = 0;
    for (int c = 0; c < 200 && cnt < 50; c++) begin
      if (src_strobe) cnt++;
      @(posedge clk);
      #1;
    end
    src_write = 1'b0;
    check_int("ptrun_pix", cnt, 50);
    passthrough = 1'b1;
    @(posedge clk);
    #1;
    passthrough = 1'b0;
    run_line(12, mk(0, 0, 8'h12, 384, 8'h00, 0, 8'h00, 0, 2,
                    8'h92, 8'h00, 0, 0, 0, 0), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
